// File: rtl/first_nios2_system_sysid_checker_pkg.sv
// Shared encodings for the system-ID checker and its read engine.
package first_nios2_system_sysid_checker_pkg;

    localparam int unsigned CNT_W = 8;

    localparam logic ADDR_ID = 1'b0;
    localparam logic ADDR_TS = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD_ID  = 3'd1,
        ST_LAT_ID = 3'd2,
        ST_RD_TS  = 3'd3,
        ST_LAT_TS = 3'd4,
        ST_DONE   = 3'd5
    } chk_state_e;

    typedef enum logic [1:0] {
        PH_IDLE = 2'd0,
        PH_READ = 2'd1,
        PH_LAT  = 2'd2
    } rd_phase_e;

endpackage

// File: rtl/first_nios2_system_sysid_checker_rd.sv
// Single Avalon-MM read: waitrequest hold, fixed read latency, stall timeout.
module first_nios2_system_sysid_checker_rd
    import first_nios2_system_sysid_checker_pkg::*;
#(
    parameter int unsigned READ_LATENCY   = 0,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        go,
    input  logic        addr,
    output logic        busy,
    output logic        accept,
    output logic        data_valid,
    output logic [31:0] data,
    output logic        timed_out,
    output logic        address,
    output logic        read,
    input  logic [31:0] readdata,
    input  logic        waitrequest
);

    localparam logic [CNT_W-1:0] LAT_N      = CNT_W'(READ_LATENCY);
    localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    rd_phase_e        phase_q, phase_d;
    logic             addr_q, addr_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] lat_q, lat_d;

    assign read      = (phase_q == PH_READ);
    assign address   = addr_q;
    assign busy      = (phase_q != PH_IDLE);
    assign accept    = read && !waitrequest;
    assign timed_out = read && waitrequest && (stall_q == STALL_LAST);
    assign data      = readdata;

    // With zero latency the word is on the bus in the accepting cycle.
    assign data_valid = (LAT_N == '0) ? accept
                      : (phase_q == PH_LAT) && (lat_q == LAT_N);

    always_comb begin
        phase_d = phase_q;
        addr_d  = addr_q;
        stall_d = stall_q;
        lat_d   = lat_q;
        if (go) begin
            phase_d = PH_READ;
            addr_d  = addr;
            stall_d = '0;
            lat_d   = '0;
        end else begin
            unique case (phase_q)
                PH_READ: begin
                    if (accept) begin
                        phase_d = (LAT_N == '0) ? PH_IDLE : PH_LAT;
                        lat_d   = CNT_W'(1);
                    end else if (timed_out) begin
                        phase_d = PH_IDLE;
                    end else begin
                        stall_d = stall_q + 1'b1;
                    end
                end
                PH_LAT: begin
                    if (lat_q == LAT_N) phase_d = PH_IDLE;
                    else                lat_d   = lat_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            phase_q <= PH_IDLE;
            addr_q  <= 1'b0;
            stall_q <= '0;
            lat_q   <= '0;
        end else begin
            phase_q <= phase_d;
            addr_q  <= addr_d;
            stall_q <= stall_d;
            lat_q   <= lat_d;
        end
    end

endmodule

// File: rtl/first_nios2_system_sysid_checker.sv
// Reads system ID and build timestamp over Avalon-MM and checks both words.
module first_nios2_system_sysid_checker
    import first_nios2_system_sysid_checker_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1380211234,
    parameter int unsigned READ_LATENCY       = 0,
    parameter int unsigned TIMEOUT_CYCLES     = 255,
    parameter bit          AUTO_START         = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        address,
    output logic        read,
    input  logic [31:0] readdata,
    input  logic        waitrequest,
    output logic        done,
    output logic        pass,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    chk_state_e  state_q, state_d;
    logic        auto_q, auto_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic        id_ok_q, id_ok_d;
    logic        ts_ok_q, ts_ok_d;
    logic        timeout_q, timeout_d;
    logic [31:0] id_value_q, id_value_d;
    logic [31:0] ts_value_q, ts_value_d;

    logic        go, go_addr;
    logic        busy, accept, data_valid, timed_out;
    logic [31:0] data;

    first_nios2_system_sysid_checker_rd #(
        .READ_LATENCY   (READ_LATENCY),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rd (
        .clock       (clock),
        .reset_n     (reset_n),
        .go          (go),
        .addr        (go_addr),
        .busy        (busy),
        .accept      (accept),
        .data_valid  (data_valid),
        .data        (data),
        .timed_out   (timed_out),
        .address     (address),
        .read        (read),
        .readdata    (readdata),
        .waitrequest (waitrequest)
    );

    always_comb begin
        state_d    = state_q;
        auto_d     = auto_q;
        done_d     = done_q;
        pass_d     = pass_q;
        id_ok_d    = id_ok_q;
        ts_ok_d    = ts_ok_q;
        timeout_d  = timeout_q;
        id_value_d = id_value_q;
        ts_value_d = ts_value_q;
        go         = 1'b0;
        go_addr    = ADDR_ID;
        unique case (state_q)
            ST_IDLE: begin
                if ((start || auto_q) && !busy) begin
                    go      = 1'b1;
                    auto_d  = 1'b0;
                    state_d = ST_RD_ID;
                end
            end
            ST_RD_ID, ST_LAT_ID: begin
                if (timed_out) begin
                    timeout_d = 1'b1;
                    done_d    = 1'b1;
                    pass_d    = 1'b0;
                    state_d   = ST_DONE;
                end else if (data_valid) begin
                    // An ID mismatch still fetches the timestamp for reporting.
                    id_value_d = data;
                    id_ok_d    = (data == EXPECTED_ID);
                    go         = 1'b1;
                    go_addr    = ADDR_TS;
                    state_d    = ST_RD_TS;
                end else if (accept) begin
                    state_d = ST_LAT_ID;
                end
            end
            ST_RD_TS, ST_LAT_TS: begin
                if (timed_out) begin
                    timeout_d = 1'b1;
                    done_d    = 1'b1;
                    pass_d    = 1'b0;
                    state_d   = ST_DONE;
                end else if (data_valid) begin
                    ts_value_d = data;
                    ts_ok_d    = (data == EXPECTED_TIMESTAMP);
                    pass_d     = id_ok_q && (data == EXPECTED_TIMESTAMP);
                    done_d     = 1'b1;
                    state_d    = ST_DONE;
                end else if (accept) begin
                    state_d = ST_LAT_TS;
                end
            end
            ST_DONE: begin
                if (start) begin
                    done_d    = 1'b0;
                    pass_d    = 1'b0;
                    id_ok_d   = 1'b0;
                    ts_ok_d   = 1'b0;
                    timeout_d = 1'b0;
                    go        = 1'b1;
                    state_d   = ST_RD_ID;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            auto_q     <= AUTO_START;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            id_ok_q    <= 1'b0;
            ts_ok_q    <= 1'b0;
            timeout_q  <= 1'b0;
            id_value_q <= '0;
            ts_value_q <= '0;
        end else begin
            state_q    <= state_d;
            auto_q     <= auto_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            id_ok_q    <= id_ok_d;
            ts_ok_q    <= ts_ok_d;
            timeout_q  <= timeout_d;
            id_value_q <= id_value_d;
            ts_value_q <= ts_value_d;
        end
    end

    assign done     = done_q;
    assign pass     = pass_q;
    assign id_ok    = id_ok_q;
    assign ts_ok    = ts_ok_q;
    assign timeout  = timeout_q;
    assign id_value = id_value_q;
    assign ts_value = ts_value_q;

endmodule

// File: tb/tb_first_nios2_system_sysid_checker.sv
// Directed + randomized bench for the system-ID checker.
module tb_first_nios2_system_sysid_checker;

    localparam logic [31:0] EXP_ID = 32'd0;
    localparam logic [31:0] EXP_TS = 32'd1380211234;
    localparam int          LAT2   = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] mem [2];

    // checker 0: zero latency, auto start, 255-cycle timeout
    logic        start0, addr0, read0, wait0;
    logic        done0, pass0, idok0, tsok0, to0;
    logic [31:0] rdata0, idv0, tsv0;

    // checker 2: two-cycle latency, manual start
    logic        start2, addr2, read2;
    logic        wait2;
    logic        done2, pass2, idok2, tsok2, to2;
    logic [31:0] rdata2, idv2, tsv2;

    int checks = 0;
    int passed = 0;

    first_nios2_system_sysid_checker dut0 (
        .clock(clk), .reset_n(rst_n), .start(start0),
        .address(addr0), .read(read0), .readdata(rdata0),
        .waitrequest(wait0), .done(done0), .pass(pass0),
        .id_ok(idok0), .ts_ok(tsok0), .timeout(to0),
        .id_value(idv0), .ts_value(tsv0)
    );

    first_nios2_system_sysid_checker #(
        .READ_LATENCY(LAT2), .TIMEOUT_CYCLES(16), .AUTO_START(1'b0)
    ) dut2 (
        .clock(clk), .reset_n(rst_n), .start(start2),
        .address(addr2), .read(read2), .readdata(rdata2),
        .waitrequest(wait2), .done(done2), .pass(pass2),
        .id_ok(idok2), .ts_ok(tsok2), .timeout(to2),
        .id_value(idv2), .ts_value(tsv2)
    );

    // Slave model for checker 0: fixed stall count per read, data by address.
    int   stall_cfg = 0;
    int   stall_cnt = 0;
    bit   stuck = 1'b0;
    int   rd_hi0 = 0;
    int   stab_err = 0;
    logic prev_wait0 = 1'b0, prev_rd0 = 1'b0, prev_addr0 = 1'b0;
    logic acc0 [$];

    assign rdata0 = mem[addr0];

    initial wait0 = 1'b0;

    always @(negedge clk) begin
        if (rst_n && prev_wait0 && prev_rd0 && !to0 &&
            !(read0 && addr0 == prev_addr0))
            stab_err++;
        prev_rd0   = read0;
        prev_addr0 = addr0;
        if (read0) begin
            rd_hi0++;
            if (stuck || stall_cnt < stall_cfg) begin
                wait0 = 1'b1;
                stall_cnt++;
            end else begin
                wait0 = 1'b0;
                stall_cnt = 0;
                acc0.push_back(addr0);
            end
        end else begin
            wait0 = 1'b0;
            stall_cnt = 0;
        end
        prev_wait0 = wait0;
    end

    // Slave model for checker 2: word valid exactly LAT2 edges after accept,
    // random junk on every other cycle.
    int   ecnt = 0;
    int   due_q [$];
    logic apq [$];
    int   nread2 = 0, run2 = 0, maxrun2 = 0;

    assign wait2 = 1'b0;

    always @(posedge clk) ecnt <= ecnt + 1;

    always @(negedge clk) begin
        if (!rst_n) begin
            due_q.delete();
            apq.delete();
        end else if (read2) begin
            due_q.push_back(ecnt + 1 + LAT2);
            apq.push_back(addr2);
        end
        if (due_q.size() > 0 && due_q[0] == ecnt + 1) begin
            rdata2 = mem[apq[0]];
            void'(due_q.pop_front());
            void'(apq.pop_front());
        end else begin
            rdata2 = $urandom;
        end
        if (read2) begin
            nread2++;
            run2++;
        end else begin
            run2 = 0;
        end
        if (run2 > maxrun2) maxrun2 = run2;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic wait_done0(input int limit, output int cyc);
        cyc = 0;
        while (!done0 && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic run0(input int limit, output int cyc);
        acc0.delete();
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        wait_done0(limit, cyc);
    endtask

    task automatic run2_t(output int cyc);
        nread2 = 0;
        maxrun2 = 0;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        cyc = 0;
        while (!done2 && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        int          cyc;
        bit          e_id, e_ts;
        logic [31:0] prev_id, prev_ts;

        rst_n  = 1'b0;
        start0 = 1'b0;
        start2 = 1'b0;
        mem[0] = EXP_ID;
        mem[1] = EXP_TS;
        repeat (3) @(negedge clk);

        chk("rst_read", 32'(read0), 0);
        chk("rst_done", 32'(done0), 0);
        chk("rst_pass", 32'(pass0), 0);
        chk("rst_timeout", 32'(to0), 0);
        chk("rst_id_value", idv0, 0);
        chk("rst_ts_value", tsv0, 0);
        chk("rst_done2", 32'(done2), 0);

        // auto start after reset release
        acc0.delete();
        rst_n = 1'b1;
        wait_done0(50, cyc);
        chk("auto_latency", 32'(cyc), 3);
        chk("auto_nreads", 32'(acc0.size()), 2);
        if (acc0.size() == 2) begin
            chk("auto_addr0", 32'(acc0[0]), 0);
            chk("auto_addr1", 32'(acc0[1]), 1);
        end
        chk("auto_pass", 32'(pass0), 1);
        chk("auto_ts_value", tsv0, EXP_TS);

        // timestamp mismatch
        mem[1] = 32'd1380211233;
        run0(50, cyc);
        chk("mm_done", 32'(done0), 1);
        chk("mm_pass", 32'(pass0), 0);
        chk("mm_id_ok", 32'(idok0), 1);
        chk("mm_ts_ok", 32'(tsok0), 0);
        chk("mm_ts_value", tsv0, 32'd1380211233);

        // five stall cycles on each read
        mem[1] = EXP_TS;
        stall_cfg = 5;
        run0(100, cyc);
        chk("stall_latency", 32'(cyc), 12);
        chk("stall_pass", 32'(pass0), 1);
        chk("stall_stable", 32'(stab_err), 0);

        // randomized words and stalls against the expected-value rules
        for (int t = 0; t < 6; t++) begin
            mem[0] = ($urandom_range(0, 2) == 0) ? $urandom : EXP_ID;
            mem[1] = ($urandom_range(0, 2) == 0) ? $urandom : EXP_TS;
            stall_cfg = $urandom_range(0, 4);
            e_id = (mem[0] == EXP_ID);
            e_ts = (mem[1] == EXP_TS);
            run0(100, cyc);
            chk("rnd_latency", 32'(cyc), 32'(2 + 2 * stall_cfg));
            chk("rnd_pass", 32'(pass0), 32'(e_id && e_ts));
            chk("rnd_id_ok", 32'(idok0), 32'(e_id));
            chk("rnd_ts_ok", 32'(tsok0), 32'(e_ts));
            chk("rnd_id_value", idv0, mem[0]);
            chk("rnd_ts_value", tsv0, mem[1]);
            chk("rnd_nreads", 32'(acc0.size()), 2);
        end

        // waitrequest stuck high: abort after 255 stall cycles
        prev_id = mem[0];
        prev_ts = mem[1];
        mem[0] = 32'hDEAD_0001;
        stuck = 1'b1;
        rd_hi0 = 0;
        run0(400, cyc);
        chk("to_latency", 32'(cyc), 255);
        chk("to_read_cycles", 32'(rd_hi0), 255);
        chk("to_read_low", 32'(read0), 0);
        chk("to_timeout", 32'(to0), 1);
        chk("to_done", 32'(done0), 1);
        chk("to_pass", 32'(pass0), 0);
        chk("to_id_kept", idv0, prev_id);
        chk("to_ts_kept", tsv0, prev_ts);
        chk("to_stable", 32'(stab_err), 0);

        // recovery with a good slave
        stuck = 1'b0;
        stall_cfg = 0;
        mem[0] = EXP_ID;
        mem[1] = EXP_TS;
        run0(50, cyc);
        chk("rec_timeout", 32'(to0), 0);
        chk("rec_pass", 32'(pass0), 1);

        // start pulsed while busy is ignored
        stall_cfg = 2;
        acc0.delete();
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        wait_done0(50, cyc);
        repeat (5) @(negedge clk);
        chk("busy_nreads", 32'(acc0.size()), 2);
        chk("busy_done", 32'(done0), 1);
        chk("busy_pass", 32'(pass0), 1);

        // reset during the timestamp read
        stall_cfg = 3;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        cyc = 0;
        while (!(read0 && addr0) && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("mid_reached_ts", 32'(read0 && addr0), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_read", 32'(read0), 0);
        chk("mid_addr", 32'(addr0), 0);
        chk("mid_done", 32'(done0), 0);
        chk("mid_id_ok", 32'(idok0), 0);
        chk("mid_id_value", idv0, 0);
        @(negedge clk);
        acc0.delete();
        rst_n = 1'b1;
        wait_done0(50, cyc);
        chk("mid_auto_latency", 32'(cyc), 9);
        chk("mid_auto_pass", 32'(pass0), 1);

        // two-cycle read latency with junk on the bus
        mem[0] = EXP_ID;
        mem[1] = EXP_TS;
        run2_t(cyc);
        chk("lat_latency", 32'(cyc), 32'(2 * (1 + LAT2)));
        chk("lat_pass", 32'(pass2), 1);
        chk("lat_id_value", idv2, EXP_ID);
        chk("lat_ts_value", tsv2, EXP_TS);
        chk("lat_nreads", 32'(nread2), 2);
        chk("lat_pulse_len", 32'(maxrun2), 1);
        chk("lat_timeout", 32'(to2), 0);

        // ID mismatch still reads and reports the timestamp
        mem[0] = 32'h1234_5678;
        run2_t(cyc);
        chk("idmm_pass", 32'(pass2), 0);
        chk("idmm_id_ok", 32'(idok2), 0);
        chk("idmm_ts_ok", 32'(tsok2), 1);
        chk("idmm_id_value", idv2, 32'h1234_5678);
        chk("idmm_ts_value", tsv2, EXP_TS);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
